// File: rtl/axi_regbank_irq.sv
// AXI4 slave register bank: ID, W1C interrupt pending, enable, raw source view
// and scratch registers, with rising-edge interrupt capture and a registered irq.
module axi_regbank_irq #(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned NUM_SCRATCH = 4,
  parameter int unsigned ID_W        = 12,
  parameter int unsigned ADDR_W      = 12,
  parameter logic [31:0] BLOCK_ID    = 32'h5A7B0001
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               s_awvalid,
  output logic               s_awready,
  input  logic [ADDR_W-1:0]  s_awaddr,
  input  logic [7:0]         s_awlen,
  input  logic [ID_W-1:0]    s_awid,
  input  logic               s_wvalid,
  output logic               s_wready,
  input  logic [31:0]        s_wdata,
  input  logic [3:0]         s_wstrb,
  input  logic               s_wlast,
  output logic               s_bvalid,
  input  logic               s_bready,
  output logic [ID_W-1:0]    s_bid,
  output logic [1:0]         s_bresp,
  input  logic               s_arvalid,
  output logic               s_arready,
  input  logic [ADDR_W-1:0]  s_araddr,
  input  logic [7:0]         s_arlen,
  input  logic [ID_W-1:0]    s_arid,
  output logic               s_rvalid,
  input  logic               s_rready,
  output logic [31:0]        s_rdata,
  output logic [ID_W-1:0]    s_rid,
  output logic [1:0]         s_rresp,
  output logic               s_rlast,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic               irq
);
  localparam int unsigned     WA_W     = ADDR_W - 2;
  localparam int unsigned     SW       = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
  localparam logic [WA_W-1:0] SCR_BASE = WA_W'(4);
  localparam logic [WA_W-1:0] MAP_END  = WA_W'(4 + NUM_SCRATCH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate, wnext;
  rstate_t rstate, rnext;

  logic [NUM_IRQ-1:0] pending, enable, raw, pend_set, pend_clr;
  logic [31:0]        scratch [NUM_SCRATCH];

  logic [WA_W-1:0] waddr;
  logic [7:0]      wlen, wcnt;
  logic            werr, aw_hs, wbeat, wmapped;
  logic [31:0]     bmask, wbits;

  logic [WA_W-1:0] raddr, rsel;
  logic [7:0]      rlen, rcnt;
  logic            rload, rd_err;
  logic [31:0]     rd_word;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_awaddr[1:0], s_araddr[1:0]};

  // ---------------- write channel ----------------
  assign aw_hs   = s_awvalid && s_awready;
  assign wbeat   = s_wvalid && s_wready;
  assign wmapped = waddr < MAP_END;

  always_comb begin
    bmask = {{8{s_wstrb[3]}}, {8{s_wstrb[2]}}, {8{s_wstrb[1]}}, {8{s_wstrb[0]}}};
    wbits = s_wdata & bmask;
  end

  always_ff @(posedge CLK) begin
    if (reset) wstate <= W_IDLE;
    else       wstate <= wnext;
  end

  always_comb begin
    wnext     = wstate;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    case (wstate)
      W_IDLE: begin
        s_awready = 1'b1;
        if (s_awvalid) wnext = W_DATA;
      end
      W_DATA: begin
        s_wready = 1'b1;
        if (s_wvalid && (s_wlast || wcnt == wlen)) wnext = W_RESP;
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) wnext = W_IDLE;
      end
      default: wnext = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      waddr <= '0;
      wlen  <= '0;
      wcnt  <= '0;
      werr  <= 1'b0;
      s_bid <= '0;
    end else if (aw_hs) begin
      waddr <= s_awaddr[ADDR_W-1:2];
      wlen  <= s_awlen;
      wcnt  <= '0;
      werr  <= 1'b0;
      s_bid <= s_awid;
    end else if (wbeat) begin
      waddr <= waddr + WA_W'(1);
      wcnt  <= wcnt + 8'd1;
      if (!wmapped) werr <= 1'b1;
    end
  end

  assign s_bresp = werr ? 2'b10 : 2'b00;

  // ---------------- register file and interrupt logic ----------------
  assign pend_set = irq_src & ~raw;
  assign pend_clr = (wbeat && waddr == WA_W'(1)) ? wbits[NUM_IRQ-1:0] : '0;

  // Set is OR-ed after the clear so a new edge survives a concurrent W1C.
  always_ff @(posedge CLK) begin
    if (reset) begin
      pending <= '0;
      enable  <= '0;
      raw     <= '0;
      irq     <= 1'b0;
      for (int unsigned k = 0; k < NUM_SCRATCH; k++) scratch[k] <= '0;
    end else begin
      raw     <= irq_src;
      irq     <= |(pending & enable);
      pending <= (pending & ~pend_clr) | pend_set;
      if (wbeat && waddr == WA_W'(2))
        enable <= (enable & ~bmask[NUM_IRQ-1:0]) | wbits[NUM_IRQ-1:0];
      if (wbeat && wmapped && waddr >= SCR_BASE)
        scratch[SW'(waddr - SCR_BASE)] <= (scratch[SW'(waddr - SCR_BASE)] & ~bmask) | wbits;
    end
  end

  // ---------------- read channel ----------------
  always_ff @(posedge CLK) begin
    if (reset) rstate <= R_IDLE;
    else       rstate <= rnext;
  end

  always_comb begin
    rnext     = rstate;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rlast   = 1'b0;
    rload     = 1'b0;
    case (rstate)
      R_IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) begin
          rnext = R_DATA;
          rload = 1'b1;
        end
      end
      R_DATA: begin
        s_rvalid = 1'b1;
        s_rlast  = (rcnt == rlen);
        if (s_rready) begin
          if (rcnt == rlen) rnext = R_IDLE;
          else              rload = 1'b1;
        end
      end
      default: rnext = R_IDLE;
    endcase
  end

  // Beat data is fetched one cycle ahead into registers, so reads observe pre-write state.
  always_comb begin
    rsel    = (rstate == R_IDLE) ? s_araddr[ADDR_W-1:2] : raddr + WA_W'(1);
    rd_word = '0;
    rd_err  = 1'b0;
    if (rsel >= MAP_END) rd_err = 1'b1;
    else if (rsel >= SCR_BASE) rd_word = scratch[SW'(rsel - SCR_BASE)];
    else begin
      case (rsel[1:0])
        2'd0:    rd_word = BLOCK_ID;
        2'd1:    rd_word = 32'(pending);
        2'd2:    rd_word = 32'(enable);
        default: rd_word = 32'(raw);
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      raddr   <= '0;
      rlen    <= '0;
      rcnt    <= '0;
      s_rid   <= '0;
      s_rdata <= '0;
      s_rresp <= '0;
    end else if (rload) begin
      raddr   <= rsel;
      s_rdata <= rd_word;
      s_rresp <= rd_err ? 2'b10 : 2'b00;
      if (rstate == R_IDLE) begin
        rcnt  <= '0;
        rlen  <= s_arlen;
        s_rid <= s_arid;
      end else begin
        rcnt <= rcnt + 8'd1;
      end
    end
  end
endmodule
